// File: rtl/masked_linear_pipe_if.sv
// Handshake and data bundle for the masked linear output pipe.
// The slave side is the pipe itself; the master side is whatever feeds
// shares and randomness in and consumes refreshed shares out.
interface masked_linear_pipe_if #(
  parameter int SHARES = 2,
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
);
  logic                              in_valid;
  logic                              in_ready;
  logic [SHARES*WIDTH-1:0]           in_shares;
  logic [STAGES*(SHARES-1)*WIDTH-1:0] r;
  logic                              out_valid;
  logic                              out_ready;
  logic [SHARES*WIDTH-1:0]           out_shares;
  logic                              busy;

  modport master (
    output in_valid, in_shares, r, out_ready,
    input  in_ready, out_valid, out_shares, busy
  );

  modport slave (
    input  in_valid, in_shares, r, out_ready,
    output in_ready, out_valid, out_shares, busy
  );
endinterface

// File: rtl/masked_linear_pipe.sv
// Share-wise GF(2) linear map plus affine constant (share 0 only), followed
// by an elastic valid/ready pipeline that re-masks every share at each
// register stage. The XOR of all output shares always equals
// MATRIX * (XOR of input shares) ^ AFFINE_C. in_ready depends
// combinationally on out_ready so a full pipe can accept and emit in the
// same cycle.
module masked_linear_pipe #(
  parameter int                       SHARES   = 2,
  parameter int                       WIDTH    = 8,
  parameter int                       STAGES   = 2,
  parameter logic [WIDTH*WIDTH-1:0]   MATRIX   = 64'h8040201008040201,
  parameter logic [WIDTH-1:0]         AFFINE_C = 8'h63
) (
  input  logic                 clk,
  input  logic                 rst_n,
  masked_linear_pipe_if.slave  bus
);

  localparam int DW = SHARES * WIDTH;
  localparam int RW = (SHARES - 1) * WIDTH;

  // Output bit j is the parity of the input bits selected by matrix row j.
  function automatic logic [WIDTH-1:0] lin_map(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] y;
    y = '0;
    for (int j = 0; j < WIDTH; j++) begin
      y[j] = ^(MATRIX[j*WIDTH +: WIDTH] & x);
    end
    return y;
  endfunction

  // Re-mask: each of the first SHARES-1 shares absorbs its own random word,
  // the last share absorbs the XOR of all of them, so the share sum is kept.
  function automatic logic [DW-1:0] refresh(input logic [DW-1:0] d,
                                            input logic [RW-1:0] rk);
    logic [DW-1:0]    o;
    logic [WIDTH-1:0] acc;
    o   = d;
    acc = '0;
    for (int i = 0; i < SHARES - 1; i++) begin
      o[i*WIDTH +: WIDTH] = d[i*WIDTH +: WIDTH] ^ rk[i*WIDTH +: WIDTH];
      acc                 = acc ^ rk[i*WIDTH +: WIDTH];
    end
    o[(SHARES-1)*WIDTH +: WIDTH] = d[(SHARES-1)*WIDTH +: WIDTH] ^ acc;
    return o;
  endfunction

  logic [DW-1:0]     front;
  logic [STAGES-1:0] valid;
  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] load;
  logic [DW-1:0]     data [STAGES];
  logic [DW-1:0]     src  [STAGES];

  // Combinational front end: linear map on every share, constant on share 0.
  always_comb begin
    // NOTE: every always_comb output gets a full default up front so no
    // path through the block leaves it unassigned and infers a latch.
    front = '0;
    for (int s = 0; s < SHARES; s++) begin
      front[s*WIDTH +: WIDTH] = lin_map(bus.in_shares[s*WIDTH +: WIDTH]);
    end
    front[0 +: WIDTH] = front[0 +: WIDTH] ^ AFFINE_C;
  end

  // Advance chain, walked from the output back: a stage moves when it holds
  // data and the slot after it is empty or moving itself.
  always_comb begin : advance_chain
    logic open_next;
    open_next = bus.out_ready;
    adv       = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      adv[k]    = valid[k] & open_next;
      open_next = ~valid[k] | adv[k];
    end
  end

  assign bus.in_ready = ~valid[0] | adv[0];

  // Load enables and load sources: stage 0 takes the front end, later
  // stages take whatever their predecessor hands over.
  always_comb begin
    load    = '0;
    load[0] = bus.in_valid & bus.in_ready;
    src[0]  = front;
    for (int k = 1; k < STAGES; k++) begin
      load[k] = adv[k-1];
      src[k]  = data[k-1];
    end
  end

  // Stage registers: valid tracks occupancy, data is refreshed on load and
  // otherwise held (draining does not clear it).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
      // NOTE: the share registers are a small register file, not RAM, so
      // they are cleared on reset; no stale mask material survives reset.
      for (int k = 0; k < STAGES; k++) begin
        data[k] <= '0;
      end
    end else begin
      // NOTE: non-blocking updates let every stage read its predecessor's
      // pre-edge value, which is what makes the shift behave as a pipeline.
      for (int k = 0; k < STAGES; k++) begin
        valid[k] <= load[k] | (valid[k] & ~adv[k]);
        if (load[k]) begin
          data[k] <= refresh(src[k], bus.r[k*RW +: RW]);
        end
      end
    end
  end

  assign bus.out_valid  = valid[STAGES-1];
  assign bus.out_shares = data[STAGES-1];
  assign bus.busy       = |valid;

endmodule

// File: doc/masked_linear_pipe.md
# masked_linear_pipe

Parametrised, share-generic masked linear/affine output stage for the pipelined masked AES S-box datapath. It applies a GF(2) bit-matrix share-wise, injects the affine constant into share 0 only, and refreshes the shares with fresh randomness at every register stage. An elastic valid/ready pipeline carries the shares. It generalises the fixed 2-share, 8-bit, combinational linear output layer to any share count, width, matrix and pipeline depth, and adds backpressure.

## Interface
Parameters:
- SHARES, 2, number of Boolean shares (d+1), ≥2
- WIDTH, 8, bits per share
- STAGES, 2, register stages, ≥1
- MATRIX, 64'h8040201008040201, WIDTH*WIDTH bits; row j at [j*WIDTH +: WIDTH]; output bit j = XOR of input bits i where row j bit i = 1
- AFFINE_C, 8'h63, WIDTH-bit constant XORed into share 0 only

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  input shares valid
- in_ready  out  1  stage 1 accepts this cycle
- in_shares  in  SHARES*WIDTH  share s at [s*WIDTH +: WIDTH]
- r  in  STAGES*(SHARES-1)*WIDTH  fresh randomness; stage k, share i at [(k*(SHARES-1)+i)*WIDTH +: WIDTH]
- out_valid  out  1  last stage holds data
- out_ready  in  1  downstream accepts
- out_shares  out  SHARES*WIDTH  output shares, same packing as in_shares
- busy  out  1  OR of all stage valid bits

## Operation
- Combinational front end: every share gets y_s = MATRIX·x_s. Share 0 additionally gets XOR AFFINE_C. No cross-share mixing.
- Stages 1..STAGES each hold a valid bit and SHARES*WIDTH data bits.
- On load of stage k, the refresh is applied:
  - Share i < SHARES-1 gets XOR r_k,i.
  - Share SHARES-1 gets XOR (XOR over i of r_k,i).
  - The r slice is sampled in the load cycle only.
- Correctness invariant: XOR of out_shares = MATRIX·(XOR of in_shares) XOR AFFINE_C.
- Stage k advances when it is valid and (k = STAGES ? out_ready : stage k+1 is empty or advancing).
- Stage k loads when its predecessor presents valid data and the stage is empty or advancing.
- Stage 1 loads on in_valid && in_ready.
- in_ready = !valid[1] || advance[1]. This is a combinational path from out_ready, which is intentional and documented.
- Data registers hold their value when not loaded. No zeroing on drain.
- Reset: all valid bits cleared and all data registers set to 0, asynchronously. In-flight data is discarded and is not replayed.

## Timing
- Reset values: out_valid=0, busy=0, out_shares=0. in_ready=1 once rst_n is deasserted.
- Latency: an input accepted at edge t is on out_shares with out_valid=1 after edge t+STAGES−1. Equivalently, it is visible in the cycle following the STAGES-th load edge, assuming no stall.
- Throughput: 1 transfer per cycle with out_ready held high.
- Stall with out_ready=0:
  - Bubbles collapse; the pipe fills to STAGES entries, then in_ready=0.
  - out_shares and out_valid stay stable until the transfer.
- Simultaneous output transfer and input transfer on a full pipe: both occur in the same cycle, with no bubble.
- rst_n assertion mid-stream: the outputs above take effect immediately, independent of the clock.
- Randomness not sampled in a cycle (stage not loading) has no effect.

## Test plan
1. **Reset behaviour.** Assert rst_n=0 mid-stream with a full pipe → out_valid=0, busy=0 and out_shares=0 immediately. After release, in_ready=1 and no stale output appears.
2. **Default parameters, single transfer.** Drive in_shares={0x3C,0x5A}, r_stage0=0x11, r_stage1=0x22, out_ready=1 → after 2 cycles out_shares={0x0F,0x0A} with out_valid=1. Unmasked XOR = 0x05.
3. **Backpressure.** Hold out_ready=0 and stream 4 inputs → in_ready drops after 2 accepts. Output stays stable. Releasing out_ready drains the inputs in order, with no loss or duplication.
4. **Full-rate streaming.** Run 256 back-to-back random inputs with random r → every output XOR equals MATRIX·(input XOR) ^ 0x63, at 1 per cycle.
5. **Non-identity configuration.** SHARES=3, STAGES=3, MATRIX = bit-reversal permutation, AFFINE_C=0xC6. Input XOR 0x01 → output XOR 0x80^0xC6=0x46. Each individual share differs from the unrefreshed value whenever r≠0.
6. **Random handshake stress.** Drive random in_valid and out_ready against a reference model → ordering and invariant hold, and busy equals the OR of the stage occupancy.
